// File: rtl/wash_sequencer.sv
// Washing-machine stage sequencer: one shared down-timer for the timed stages,
// a fill/drain watchdog, lid pause handling and fully registered actuator outputs.
module wash_sequencer #(
  parameter int unsigned WASH_TIME    = 9,
  parameter int unsigned RINSE_TIME   = 6,
  parameter int unsigned SPIN_TIME    = 5,
  parameter int unsigned ALERT_TIME   = 3,
  parameter int unsigned FILL_TIMEOUT = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       lid_open,
  input  logic [1:0] temp_sel,
  input  logic       water_full,
  input  logic       water_empty,
  output logic       agitator,
  output logic       spin,
  output logic       pump,
  output logic       alert,
  output logic       cold_valve,
  output logic       hot_valve,
  output logic [3:0] timer_bus,
  output logic [3:0] stage_bus,
  output logic       busy
);
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FILL_W  = 4'd1,
    S_WASH    = 4'd2,
    S_DRAIN_W = 4'd3,
    S_FILL_R  = 4'd4,
    S_RINSE   = 4'd5,
    S_DRAIN_R = 4'd6,
    S_SPIN    = 4'd7,
    S_DONE    = 4'd8,
    S_FAULT   = 4'd9
  } state_t;

  typedef struct packed {
    logic busy;
    logic agitator;
    logic spin;
    logic pump;
    logic alert;
    logic cold_valve;
    logic hot_valve;
  } act_t;

  localparam logic [3:0] WASH_T  = 4'(WASH_TIME);
  localparam logic [3:0] RINSE_T = 4'(RINSE_TIME);
  localparam logic [3:0] SPIN_T  = 4'(SPIN_TIME);
  localparam logic [3:0] ALERT_T = 4'(ALERT_TIME);
  localparam logic [3:0] WD_LAST = 4'(FILL_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [3:0] wd_q, wd_d;
  act_t       act_q, act_d;

  logic paused, step, timed, watched, timer_expire, wd_expire, pause_d;

  // IDLE, DONE and FAULT ignore the lid; everywhere else an open lid freezes time.
  assign paused       = lid_open && !(state_q inside {S_IDLE, S_DONE, S_FAULT});
  assign step         = tick && !paused;
  assign timed        = state_q inside {S_WASH, S_RINSE, S_SPIN, S_DONE};
  assign watched      = state_q inside {S_FILL_W, S_DRAIN_W, S_FILL_R, S_DRAIN_R};
  assign timer_expire = step && (timer_q == 4'd1);
  assign wd_expire    = step && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      wd_q    <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wd_q    <= wd_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && !lid_open) state_d = S_FILL_W;
      S_FILL_W:  if (water_full && !paused) state_d = S_WASH;
                 else if (wd_expire) state_d = S_FAULT;
      S_WASH:    if (timer_expire) state_d = S_DRAIN_W;
      S_DRAIN_W: if (water_empty) state_d = S_FILL_R;
                 else if (wd_expire) state_d = S_FAULT;
      S_FILL_R:  if (water_full && !paused) state_d = S_RINSE;
                 else if (wd_expire) state_d = S_FAULT;
      S_RINSE:   if (timer_expire) state_d = S_DRAIN_R;
      S_DRAIN_R: if (water_empty) state_d = S_SPIN;
                 else if (wd_expire) state_d = S_FAULT;
      S_SPIN:    if (timer_expire) state_d = S_DONE;
      S_DONE:    if (timer_expire) state_d = S_IDLE;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Shared timer reloads on entry to each timed stage; the watchdog restarts on any change.
  always_comb begin
    timer_d = timer_q;
    wd_d    = wd_q;
    if (state_d != state_q) begin
      wd_d = '0;
      case (state_d)
        S_WASH:  timer_d = WASH_T;
        S_RINSE: timer_d = RINSE_T;
        S_SPIN:  timer_d = SPIN_T;
        S_DONE:  timer_d = ALERT_T;
        default: timer_d = '0;
      endcase
    end else begin
      if (timed && step)   timer_d = timer_q - 4'd1;
      if (watched && step) wd_d    = wd_q + 4'd1;
    end
  end

  always_comb begin
    act_d      = '0;
    pause_d    = lid_open && !(state_d inside {S_IDLE, S_DONE, S_FAULT});
    act_d.busy = (state_d != S_IDLE);
    case (state_d)
      S_FILL_W: begin
        act_d.cold_valve = (temp_sel != 2'b10);
        act_d.hot_valve  = (temp_sel == 2'b01) || (temp_sel == 2'b10);
      end
      S_FILL_R:           act_d.cold_valve = 1'b1;
      S_WASH, S_RINSE:    act_d.agitator   = 1'b1;
      S_DRAIN_W, S_DRAIN_R: act_d.pump     = 1'b1;
      S_SPIN: begin
        act_d.spin = 1'b1;
        act_d.pump = 1'b1;
      end
      S_DONE:             act_d.alert      = 1'b1;
      S_FAULT: begin
        act_d.alert = 1'b1;
        act_d.pump  = 1'b1;
      end
      default: ;
    endcase
    if (pause_d) begin
      act_d.agitator   = 1'b0;
      act_d.spin       = 1'b0;
      act_d.cold_valve = 1'b0;
      act_d.hot_valve  = 1'b0;
    end
  end

  assign agitator   = act_q.agitator;
  assign spin       = act_q.spin;
  assign pump       = act_q.pump;
  assign alert      = act_q.alert;
  assign cold_valve = act_q.cold_valve;
  assign hot_valve  = act_q.hot_valve;
  assign busy       = act_q.busy;
  assign timer_bus  = timer_q;
  assign stage_bus  = state_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed scenarios plus randomized episodes, every
// cycle compared against a table-driven stage model kept in the bench.
module tb_wash_sequencer;
  localparam int WASH_T  = 9;
  localparam int RINSE_T = 6;
  localparam int SPIN_T  = 5;
  localparam int ALERT_T = 3;
  localparam int FILL_TO = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick, start, lid_open, water_full, water_empty;
  logic [1:0] temp_sel;
  logic       agitator, spin, pump, alert, cold_valve, hot_valve, busy;
  logic [3:0] timer_bus, stage_bus;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  // Model: stage successor and timer load for each stage code.
  int next_stage[10] = '{0, 2, 3, 4, 5, 6, 7, 8, 0, 9};
  int load_time[10]  = '{0, 0, WASH_T, 0, 0, RINSE_T, 0, SPIN_T, ALERT_T, 0};
  int m_stage, m_timer, m_wd;
  logic [14:0] m_out;

  int tick_cnt[16];
  logic [3:0] exp_q[$];
  logic [3:0] seen_q[$];

  wash_sequencer #(
    .WASH_TIME(WASH_T), .RINSE_TIME(RINSE_T), .SPIN_TIME(SPIN_T),
    .ALERT_TIME(ALERT_T), .FILL_TIMEOUT(FILL_TO)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .lid_open(lid_open),
    .temp_sel(temp_sel), .water_full(water_full), .water_empty(water_empty),
    .agitator(agitator), .spin(spin), .pump(pump), .alert(alert),
    .cold_valve(cold_valve), .hot_valve(hot_valve), .timer_bus(timer_bus),
    .stage_bus(stage_bus), .busy(busy)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---- scoreboard ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  function automatic logic [14:0] dut_vec();
    return {busy, stage_bus, timer_bus, agitator, spin, pump, alert, cold_valve, hot_valve};
  endfunction

  function automatic logic [14:0] model_outs(int s, logic lid, logic [1:0] ts, int t);
    logic ag, sp, pu, al, cv, hv;
    ag = (s == 2) || (s == 5);
    sp = (s == 7);
    pu = (s == 3) || (s == 6) || (s == 7) || (s == 9);
    al = (s == 8) || (s == 9);
    cv = (s == 4) || (s == 1 && ts != 2'b10);
    hv = (s == 1) && (ts == 2'b01 || ts == 2'b10);
    if (lid && s != 0 && s != 8 && s != 9) begin
      ag = 1'b0; sp = 1'b0; cv = 1'b0; hv = 1'b0;
    end
    return {s != 0, 4'(s), 4'(t), ag, sp, pu, al, cv, hv};
  endfunction

  task automatic model_reset();
    m_stage = 0; m_timer = 0; m_wd = 0; m_out = '0;
  endtask

  task automatic model_step();
    int s, ns, nt, nw;
    bit paused, run, fill, drain;
    s      = m_stage;
    ns     = s; nt = m_timer; nw = m_wd;
    paused = lid_open && !(s == 0 || s == 8 || s == 9);
    run    = tick && !paused;
    fill   = (s == 1) || (s == 4);
    drain  = (s == 3) || (s == 6);
    if (s == 0) begin
      if (start && !lid_open) ns = 1;
    end else if (fill || drain) begin
      if (fill ? (water_full && !paused) : water_empty) ns = next_stage[s];
      else if (run) begin
        nw = m_wd + 1;
        if (nw == FILL_TO) ns = 9;
      end
    end else if (load_time[s] != 0 && run) begin
      nt = m_timer - 1;
      if (nt == 0) ns = next_stage[s];
    end
    if (ns != s) begin
      nw = 0;
      nt = load_time[ns];
    end
    m_stage = ns; m_timer = nt; m_wd = nw;
    m_out   = model_outs(ns, lid_open, temp_sel, nt);
  endtask

  // ---- driver tasks ----
  task automatic clear_in();
    tick = 0; start = 0; lid_open = 0; water_full = 0; water_empty = 0; temp_sel = 2'b00;
  endtask

  // One clock: model and DUT see the same inputs; outputs compared on the falling edge.
  task automatic cyc();
    int   pre_s;
    logic pre_t;
    pre_s = stage_bus;
    pre_t = tick;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc_no++;
    if (pre_t) tick_cnt[pre_s]++;
    if (stage_bus != 4'(pre_s)) seen_q.push_back(stage_bus);
    check("cycle", dut_vec(), m_out);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("reset_async", dut_vec(), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_counts();
    foreach (tick_cnt[i]) tick_cnt[i] = 0;
    seen_q.delete();
  endtask

  // Sensors answer on demand, tick every other clock, until the model reaches the target.
  task automatic run_auto(input string tag, input int stop_s, input int stop_t, input int max_c);
    for (int i = 0; i < max_c; i++) begin
      if (m_stage == stop_s && (stop_t < 0 || m_timer == stop_t)) break;
      tick        = (cyc_no % 2 == 1);
      water_full  = (m_stage == 1) || (m_stage == 4);
      water_empty = (m_stage == 3) || (m_stage == 6);
      cyc();
    end
    tick = 0; water_full = 0; water_empty = 0;
    check(tag, stage_bus, stop_s);
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  // ---- main sequence ----
  initial begin
    clear_in();
    model_reset();
    @(negedge clk);
    apply_reset();

    // Nominal run with warm water.
    temp_sel = 2'b01;
    clear_counts();
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0};
    pulse_start();
    for (int i = 0; i < 400 && m_stage != 0; i++) begin
      tick        = (i % 2 == 1);
      water_full  = (m_stage == 1) || (m_stage == 4);
      water_empty = (m_stage == 3) || (m_stage == 6);
      cyc();
      check("nom_valves", {cold_valve, hot_valve},
            (m_stage == 1) ? 2'b11 : (m_stage == 4) ? 2'b10 : 2'b00);
    end
    clear_in();
    check("nom_back_idle", stage_bus, 0);
    check("nom_seq_len", seen_q.size(), exp_q.size());
    while (exp_q.size() > 0 && seen_q.size() > 0)
      check("nom_seq", seen_q.pop_front(), exp_q.pop_front());
    check("nom_wash_ticks", tick_cnt[2], WASH_T);
    check("nom_rinse_ticks", tick_cnt[5], RINSE_T);
    check("nom_spin_ticks", tick_cnt[7], SPIN_T);
    check("nom_alert_ticks", tick_cnt[8], ALERT_T);

    // Lid pause in WASH at timer 4.
    apply_reset();
    pulse_start();
    run_auto("pause_reach", 2, 4, 200);
    lid_open = 1;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 2 == 0);
      cyc();
    end
    tick = 0;
    check("pause_agitator", agitator, 0);
    check("pause_timer", timer_bus, 4);
    check("pause_stage", stage_bus, 2);
    lid_open = 0;
    cyc();
    check("resume_agitator", agitator, 1);
    clear_counts();
    for (int i = 0; i < 40 && m_stage == 2; i++) begin
      tick = (i % 2 == 0);
      cyc();
    end
    tick = 0;
    check("resume_ticks", tick_cnt[2], 4);
    check("resume_stage", stage_bus, 3);

    // Fill watchdog fault.
    apply_reset();
    temp_sel = 2'b10;
    pulse_start();
    for (int k = 1; k <= FILL_TO; k++) begin
      tick = 1; cyc(); tick = 0;
      if (k == FILL_TO - 1) check("fault_pre", stage_bus, 1);
      if (k == FILL_TO) begin
        check("fault_stage", stage_bus, 9);
        check("fault_acts", {alert, pump, cold_valve, hot_valve}, 4'b1100);
      end
      cyc();
    end
    pulse_start();
    cyc();
    check("fault_sticky", stage_bus, 9);

    // Sensor beats watchdog in FILL_R.
    apply_reset();
    pulse_start();
    run_auto("race_reach", 4, -1, 200);
    for (int k = 1; k < FILL_TO; k++) begin
      tick = 1; cyc(); tick = 0; cyc();
    end
    tick = 1; water_full = 1;
    cyc();
    tick = 0; water_full = 0;
    check("race_stage", stage_bus, 5);
    check("race_timer", timer_bus, RINSE_T);

    // Asynchronous reset mid-SPIN.
    apply_reset();
    pulse_start();
    run_auto("spin_reach", 7, 3, 300);
    #2;
    reset = 1;
    #1;
    check("rst_spin", spin, 0);
    check("rst_pump", pump, 0);
    check("rst_stage", stage_bus, 0);
    check("rst_timer", timer_bus, 0);
    check("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset = 0;

    // temp_sel 11 fills cold; start under an open lid is refused.
    temp_sel = 2'b11;
    pulse_start();
    check("temp11_valves", {cold_valve, hot_valve}, 2'b10);
    apply_reset();
    lid_open = 1; start = 1;
    cyc(); cyc();
    start = 0; lid_open = 0;
    check("lid_start", stage_bus, 0);

    // Randomized episodes.
    for (int ep = 0; ep < 16; ep++) begin
      apply_reset();
      clear_in();
      for (int i = 0; i < 220; i++) begin
        tick        = ($urandom_range(0, 2) == 0);
        start       = ($urandom_range(0, 9) == 0);
        lid_open    = lid_open ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 24) == 0);
        temp_sel    = 2'($urandom_range(0, 3));
        water_full  = ($urandom_range(0, 6) == 0);
        water_empty = ($urandom_range(0, 6) == 0);
        if ($urandom_range(0, 299) == 0) apply_reset();
        else cyc();
      end
    end
    clear_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
